// File: rtl/pipeline_controller_pkg.sv
// Shared definitions for the pipeline controller: state encoding and the
// legal range of the redirect flush window.
package pipeline_controller_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MC_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;

  localparam int FLUSH_CYCLES_MIN = 1;
  localparam int FLUSH_CYCLES_MAX = 7;
  localparam int FLUSH_CNT_W      = 3;

  typedef enum logic [1:0] {
    S_RUN     = ST_RUN,
    S_MC_WAIT = ST_MC_WAIT,
    S_FLUSH   = ST_FLUSH
  } ctrl_state_e;

  // Reload value for the flush window (cycles remaining after the redirect
  // cycle itself), clamped into the legal range.
  function automatic logic [FLUSH_CNT_W-1:0] flush_reload(input int n);
    if (n <= FLUSH_CYCLES_MIN) return '0;
    if (n >= FLUSH_CYCLES_MAX) return FLUSH_CNT_W'(FLUSH_CYCLES_MAX - 1);
    return FLUSH_CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipeline_controller_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Central stall/flush/hold sequencer for the IF/ID/EX pipeline registers.
// Outputs are Mealy; only state, flush window and perf counters are registered.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_stall_i,
  input  logic             redirect_i,
  input  logic             icache_busywait_i,
  input  logic             dcache_busywait_i,
  input  logic             mc_start_i,
  input  logic             mc_done_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             ex_hold_o,
  output logic             busywait_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = flush_reload(FLUSH_CYCLES);
  localparam bit MULTI_FLUSH = (FLUSH_RELOAD != '0);

  ctrl_state_e            state;
  logic [FLUSH_CNT_W-1:0] flush_left;
  logic                   busy;
  logic                   accept_redirect;

  assign busy = icache_busywait_i | dcache_busywait_i;

  always_comb begin
    stall_if_o      = 1'b0;
    stall_id_o      = 1'b0;
    flush_if_id_o   = 1'b0;
    flush_id_ex_o   = 1'b0;
    ex_hold_o       = 1'b0;
    busywait_o      = busy;
    accept_redirect = 1'b0;
    unique case (state)
      S_RUN: begin
        // Redirect outranks everything: any stalled instruction is wrong-path.
        if (redirect_i) begin
          flush_if_id_o   = 1'b1;
          flush_id_ex_o   = 1'b1;
          accept_redirect = !busy;
        end else if (mc_start_i) begin
          stall_if_o = 1'b1;
          stall_id_o = 1'b1;
          ex_hold_o  = !mc_done_i;
        end else if (load_stall_i) begin
          stall_if_o = 1'b1;
          stall_id_o = 1'b1;
        end
      end
      S_MC_WAIT: begin
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
        ex_hold_o  = !mc_done_i;
      end
      S_FLUSH: begin
        flush_if_id_o = 1'b1;
        if (redirect_i) begin
          flush_id_ex_o   = 1'b1;
          accept_redirect = !busy;
        end
      end
      default: ;
    endcase
    if (rst_i) begin
      stall_if_o      = 1'b0;
      stall_id_o      = 1'b0;
      flush_if_id_o   = 1'b0;
      flush_id_ex_o   = 1'b0;
      ex_hold_o       = 1'b0;
      busywait_o      = 1'b0;
      accept_redirect = 1'b0;
    end
  end

  // A global busywait freezes the sequencer; held requests are taken afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_RUN;
      flush_left <= '0;
    end else if (!busy) begin
      unique case (state)
        S_RUN: begin
          if (redirect_i) begin
            if (MULTI_FLUSH) begin
              flush_left <= FLUSH_RELOAD;
              state      <= S_FLUSH;
            end
          end else if (mc_start_i && !mc_done_i) begin
            state <= S_MC_WAIT;
          end
        end
        S_MC_WAIT: begin
          if (mc_done_i) state <= S_RUN;
        end
        S_FLUSH: begin
          if (redirect_i) begin
            flush_left <= FLUSH_RELOAD;
          end else if (flush_left <= FLUSH_CNT_W'(1)) begin
            flush_left <= '0;
            state      <= S_RUN;
          end else begin
            flush_left <= flush_left - FLUSH_CNT_W'(1);
          end
        end
        default: begin
          state      <= S_RUN;
          flush_left <= '0;
        end
      endcase
    end
  end

  pipeline_controller_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .clr   (rst_i),
    .inc   (stall_id_o | busywait_o),
    .count (stall_cnt_o)
  );

  pipeline_controller_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .clr   (rst_i),
    .inc   (accept_redirect),
    .count (flush_cnt_o)
  );

endmodule
